vec_alu_sequencer: RTL and testbench

Sequences vector ALU instructions through the shared two-stage execute pipe (X, X2). It accepts one vector command, then issues one element pair per cycle into the pipe and tracks in-flight elements with a latency-matched tag shift register. It writes returning results back into a result vector, or accumulates them into a scalar for dot product, and pulses `done` when the last element has retired. It sits between decode/register-read and the execute pipe, and is the pipe's only issuer.

---
 rtl/vec_alu_sequencer_if.sv | 38 +++
 rtl/vec_alu_sequencer.sv | 166 ++++++++++++++++
 tb/tb_vec_alu_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/vec_alu_sequencer_if.sv
// Command, execute-pipe and result bundle between decode/register-read,
// the vector ALU sequencer and the shared two-stage execute pipe.
interface vec_alu_sequencer_if #(
  parameter int unsigned LANES = 8,
  parameter int unsigned W     = 16
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd_opcode;
  logic [3:0]           cmd_len;
  logic [LANES*W-1:0]   cmd_a;
  logic [LANES*W-1:0]   cmd_b;
  logic                 stall;
  logic                 alu_valid;
  logic [15:0]          alu_ins;
  logic [W-1:0]         alu_op1;
  logic [W-1:0]         alu_op2;
  logic [W-1:0]         alu_result;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [LANES*W-1:0]   res_vec;
  logic [W-1:0]         res_scalar;

  // Requester side: decode plus the execute pipe returning results
  modport master (
    output cmd_valid, cmd_opcode, cmd_len, cmd_a, cmd_b, stall, alu_result,
    input  cmd_ready, alu_valid, alu_ins, alu_op1, alu_op2,
           busy, done, err, res_vec, res_scalar
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_len, cmd_a, cmd_b, stall, alu_result,
    output cmd_ready, alu_valid, alu_ins, alu_op1, alu_op2,
           busy, done, err, res_vec, res_scalar
  );
endinterface

// File: rtl/vec_alu_sequencer.sv
// Issues one element pair per cycle of a vector command into the execute pipe
// and collects returning results into a result vector or a dot-product scalar.
module vec_alu_sequencer #(
  parameter int unsigned LANES = 8,
  parameter int unsigned W     = 16,
  parameter int unsigned LAT   = 2
) (
  input logic                clk,
  input logic                reset,
  vec_alu_sequencer_if.slave bus
);
  localparam int unsigned LW = 4;
  localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_DOT = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [3:0]         opcode_q;
  logic [LW-1:0]      len_q;
  logic [LANES*W-1:0] a_q;
  logic [LANES*W-1:0] b_q;
  logic [IW-1:0]      idx_q;
  logic [LW-1:0]      ret_cnt_q;
  logic [LAT-1:0]     tag_vld_q;
  logic [IW-1:0]      tag_idx_q [LAT];

  logic               cmd_ready_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [LANES*W-1:0] res_vec_q;
  logic [W-1:0]       res_scalar_q;

  logic               issue_c;
  logic               retire_c;
  logic [IW-1:0]      retire_idx_c;
  logic               op_legal_c;
  logic [LW-1:0]      len_clamped_c;
  logic               last_issue_c;

  always_comb begin
    op_legal_c = 1'b0;
    case (bus.cmd_opcode)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_DOT: op_legal_c = 1'b1;
      default:                                op_legal_c = 1'b0;
    endcase
  end

  assign len_clamped_c = (bus.cmd_len > LW'(LANES)) ? LW'(LANES) : bus.cmd_len;
  assign last_issue_c  = (LW'(idx_q) == (len_q - LW'(1)));

  // Issue is decided in-cycle so that stall suppresses the current cycle only
  assign issue_c       = (state == S_ISSUE) && !bus.stall;
  assign retire_c      = tag_vld_q[LAT-1];
  assign retire_idx_c  = tag_idx_q[LAT-1];

  assign bus.alu_valid = issue_c;
  assign bus.alu_ins   = issue_c ? {opcode_q, 12'b0} : 16'b0;
  assign bus.alu_op1   = issue_c ? a_q[idx_q*W +: W] : W'(0);
  assign bus.alu_op2   = issue_c ? b_q[idx_q*W +: W] : W'(0);

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.res_vec    = res_vec_q;
  assign bus.res_scalar = res_scalar_q;

  // Sequencer FSM, tag pipeline and result collection
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      opcode_q     <= 4'b0;
      len_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      idx_q        <= '0;
      ret_cnt_q    <= '0;
      tag_vld_q    <= '0;
      for (int unsigned i = 0; i < LAT; i++) tag_idx_q[i] <= '0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      res_vec_q    <= '0;
      res_scalar_q <= '0;
    end else begin
      done_q <= 1'b0;

      // Tag slot tracks each pipe stage; stalled and idle cycles insert bubbles
      tag_vld_q[0] <= issue_c;
      tag_idx_q[0] <= idx_q;
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end

      if (retire_c) begin
        if (opcode_q == OP_DOT) res_scalar_q <= res_scalar_q + bus.alu_result;
        else                    res_vec_q[retire_idx_c*W +: W] <= bus.alu_result;
        ret_cnt_q <= ret_cnt_q + LW'(1);
      end

      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            opcode_q     <= bus.cmd_opcode;
            len_q        <= len_clamped_c;
            a_q          <= bus.cmd_a;
            b_q          <= bus.cmd_b;
            idx_q        <= '0;
            ret_cnt_q    <= '0;
            res_vec_q    <= '0;
            res_scalar_q <= '0;
            err_q        <= 1'b0;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            if (!op_legal_c) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= S_DONE;
            end else if (bus.cmd_len == LW'(0)) begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (issue_c) begin
            idx_q <= idx_q + IW'(1);
            if (last_issue_c) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (ret_cnt_q == len_q) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Bench for vec_alu_sequencer: a command table with hand-derived results plus
// a reset-abort sequence, driven against a behavioural two-stage execute pipe.
module tb_vec_alu_sequencer;
  localparam int unsigned LANES = 8;
  localparam int unsigned W     = 16;
  localparam int unsigned LAT   = 2;

  typedef struct {
    logic [3:0]         op;
    logic [3:0]         len;
    logic [LANES*W-1:0] a;
    logic [LANES*W-1:0] b;
    logic [15:0]        stall_mask;
    logic               exp_err;
    logic [LANES*W-1:0] exp_vec;
    logic [W-1:0]       exp_scalar;
    int                 exp_done;
  } vec_t;

  typedef struct {
    logic               err;
    logic [LANES*W-1:0] vec;
    logic [W-1:0]       scalar;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb[$];
  vec_t vecs[9];
  vec_t rv_abort;
  vec_t rv_after;

  vec_alu_sequencer_if #(.LANES(LANES), .W(W)) bus ();

  vec_alu_sequencer #(.LANES(LANES), .W(W), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural execute pipe: sub is rx-ra, dot (1110) multiplies
  function automatic logic [W-1:0] pipe_fn(input logic [3:0] op, input logic [W-1:0] ra,
                                           input logic [W-1:0] rx);
    logic [2*W-1:0] p;
    p = ra * rx;
    case (op)
      4'b0000: return W'(ra + rx);
      4'b0001: return W'(rx - ra);
      4'b0010, 4'b1110: return p[W-1:0];
      4'b0011: return (ra != '0) ? W'(rx / ra) : '1;
      default: return 16'hBAD0;
    endcase
  endfunction

  logic [W-1:0] pipe_q [LAT];
  always @(posedge clk) begin
    pipe_q[0] <= bus.alu_valid ? pipe_fn(bus.alu_ins[15:12], bus.alu_op1, bus.alu_op2) : 16'hDEAD;
    for (int i = 1; i < int'(LAT); i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign bus.alu_result = pipe_q[LAT-1];

  function automatic logic [LANES*W-1:0] pk(input logic [15:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v, input int rst_at);
    exp_t               e;
    exp_t               got;
    int                 n_exp;
    int                 n_iss;
    int                 k;
    bit                 seen_done;
    logic [LANES*W-1:0] av;
    logic [LANES*W-1:0] bv;
    av = v.a;
    bv = v.b;
    n_exp = (v.exp_err || v.len == 4'd0) ? 0 : ((v.len > 4'd8) ? 8 : int'(v.len));
    e.err = v.exp_err;
    e.vec = v.exp_vec;
    e.scalar = v.exp_scalar;
    sb.push_back(e);

    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = v.op;
    bus.cmd_len    = v.len;
    bus.cmd_a      = v.a;
    bus.cmd_b      = v.b;
    bus.stall      = 1'b0;
    #1;
    chk("cmd_ready_idle", 128'(bus.cmd_ready), 128'(1'b1));
    @(posedge clk);
    k = 0;
    n_iss = 0;
    seen_done = 1'b0;
    while (!seen_done && k < 40) begin
      @(negedge clk);
      k++;
      // A second command offered mid-operation must be ignored
      bus.cmd_valid = (k == 2 && v.exp_done > 3);
      if (k == 2) begin
        bus.cmd_opcode = 4'b0011;
        bus.cmd_len    = 4'd1;
      end
      bus.stall = (k < 16) ? v.stall_mask[k] : 1'b0;
      if (rst_at != 0 && k == rst_at) reset = 1'b1;
      #1;
      if (k == 1) chk("busy_active", 128'(bus.busy), 128'(1'b1));
      if (bus.stall && n_iss < n_exp) chk("stall_blocks_issue", 128'(bus.alu_valid), 128'(1'b0));
      if (bus.alu_valid) begin
        chk("alu_op1", 128'(bus.alu_op1), 128'(av[n_iss*16 +: 16]));
        chk("alu_op2", 128'(bus.alu_op2), 128'(bv[n_iss*16 +: 16]));
        chk("alu_ins", 128'(bus.alu_ins), 128'({v.op, 12'b0}));
        n_iss++;
      end else begin
        chk("alu_idle_zero", 128'({bus.alu_ins, bus.alu_op1, bus.alu_op2}), 128'(0));
      end
      if (rst_at != 0 && k == rst_at) begin
        @(negedge clk);
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        #1;
        chk("rst_busy", 128'(bus.busy), 128'(1'b0));
        chk("rst_cmd_ready", 128'(bus.cmd_ready), 128'(1'b1));
        chk("rst_no_done", 128'(bus.done), 128'(1'b0));
        void'(sb.pop_front());
        return;
      end
      if (bus.done) begin
        seen_done = 1'b1;
        chk("done_cycle", 128'(k), 128'(v.exp_done));
        chk("issue_count", 128'(n_iss), 128'(n_exp));
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 128'(0), 128'(1));
        end else begin
          got = sb.pop_front();
          chk("err", 128'(bus.err), 128'(got.err));
          chk("res_vec", 128'(bus.res_vec), 128'(got.vec));
          chk("res_scalar", 128'(bus.res_scalar), 128'(got.scalar));
        end
      end
    end
    if (!seen_done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done required=done_by_cycle_%0d", v.exp_done);
      return;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.stall = 1'b0;
    #1;
    chk("done_one_cycle", 128'(bus.done), 128'(1'b0));
    chk("cmd_ready_back", 128'(bus.cmd_ready), 128'(1'b1));
    chk("busy_clear", 128'(bus.busy), 128'(1'b0));
    chk("res_vec_held", 128'(bus.res_vec), 128'(got.vec));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_opcode = 4'b0;
    bus.cmd_len = 4'd0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.stall = 1'b0;

    // op, len, A, B, stall mask (bit k = cycle k), err, res_vec, res_scalar, done cycle
    vecs[0] = '{4'b0000, 4'd3, pk(1, 2, 3, 0, 0, 0, 0, 0), pk(10, 20, 30, 0, 0, 0, 0, 0),
                16'h0, 1'b0, pk(11, 22, 33, 0, 0, 0, 0, 0), 16'd0, 7};
    vecs[1] = '{4'b0001, 4'd2, pk(5, 1, 9, 9, 0, 0, 0, 0), pk(7, 0, 9, 9, 0, 0, 0, 0),
                16'h0, 1'b0, pk(2, 16'hFFFF, 0, 0, 0, 0, 0, 0), 16'd0, 6};
    vecs[2] = '{4'b1110, 4'd8, {8{16'h0100}}, {8{16'h0100}},
                16'h0, 1'b0, '0, 16'd0, 12};
    vecs[3] = '{4'b1110, 4'd8, pk(1, 2, 3, 4, 5, 6, 7, 8), {8{16'h0002}},
                16'h0, 1'b0, '0, 16'd72, 12};
    vecs[4] = '{4'b0010, 4'd4, pk(3, 4, 5, 16'h0100, 0, 0, 0, 0), pk(7, 8, 9, 16'h0300, 0, 0, 0, 0),
                16'h000C, 1'b0, pk(21, 32, 45, 0, 0, 0, 0, 0), 16'd0, 10};
    vecs[5] = '{4'b0111, 4'd3, pk(1, 2, 3, 0, 0, 0, 0, 0), pk(1, 2, 3, 0, 0, 0, 0, 0),
                16'h0, 1'b1, '0, 16'd0, 1};
    vecs[6] = '{4'b0000, 4'd0, pk(1, 2, 3, 0, 0, 0, 0, 0), pk(1, 2, 3, 0, 0, 0, 0, 0),
                16'h0, 1'b0, '0, 16'd0, 1};
    vecs[7] = '{4'b0000, 4'd12, pk(1, 2, 3, 4, 5, 6, 7, 8), pk(100, 200, 300, 400, 500, 600, 700, 800),
                16'h0, 1'b0, pk(101, 202, 303, 404, 505, 606, 707, 808), 16'd0, 12};
    vecs[8] = '{4'b0011, 4'd1, pk(2, 0, 0, 0, 0, 0, 0, 0), pk(10, 0, 0, 0, 0, 0, 0, 0),
                16'h0, 1'b0, pk(5, 0, 0, 0, 0, 0, 0, 0), 16'd0, 5};
    rv_abort = '{4'b0000, 4'd8, pk(1, 2, 3, 4, 5, 6, 7, 8), pk(1, 2, 3, 4, 5, 6, 7, 8),
                 16'h0, 1'b0, '0, 16'd0, 99};
    rv_after = '{4'b0000, 4'd1, pk(40, 0, 0, 0, 0, 0, 0, 0), pk(2, 0, 0, 0, 0, 0, 0, 0),
                 16'h0, 1'b0, pk(42, 0, 0, 0, 0, 0, 0, 0), 16'd0, 5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_cmd_ready", 128'(bus.cmd_ready), 128'(1'b1));
    chk("rst_flags", 128'({bus.busy, bus.done, bus.err, bus.alu_valid}), 128'(0));
    chk("rst_alu_bus", 128'({bus.alu_ins, bus.alu_op1, bus.alu_op2}), 128'(0));
    chk("rst_results", 128'(bus.res_vec), 128'(0));
    chk("rst_scalar", 128'(bus.res_scalar), 128'(0));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_cmd(vecs[i], 0);

    // Abort a long add in cycle 2, then a short add must see no stale retires
    run_cmd(rv_abort, 2);
    run_cmd(rv_after, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
